// File: rtl/synchroniser.sv
// Multi-stage flop chain bringing asynchronous inputs into the clk domain.
// Ports: clk, reset (async, active-low), d (raw inputs), q (last stage).
module synchroniser #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *)
  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++)
        chain[s] <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++)
        chain[s] <= chain[s-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces WIDTH raw inputs; flags accepted edges.
// Ports: clk, reset (async, active-low), d_in, d_out, rise, fall.
module input_conditioner #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync;

  synchroniser #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_in),
    .q     (sync)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          up;
    logic          dn;

    // cnt tracks how long sync has disagreed with lvl;
    // any agreement throws the partial count away.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        lvl <= 1'b0;
        up  <= 1'b0;
        dn  <= 1'b0;
      end else begin
        up <= 1'b0;
        dn <= 1'b0;
        if (sync[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
          lvl <= sync[i];
          up  <= sync[i];
          dn  <= ~sync[i];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign d_out[i] = lvl;
    assign rise[i]  = up;
    assign fall[i]  = dn;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1: number of independent channels, legal 1..32.
REQ-002 The module SHALL have parameter STAGES, default 2: synchroniser flop stages per channel, legal 2..8.
REQ-003 The module SHALL have parameter FILTER_LEN, default 4: consecutive stable synchronised cycles required to accept a change, legal 1..65535.
REQ-004 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-low reset.
REQ-006 d_in  input  WIDTH  Asynchronous raw inputs, e.g. mech sensors and switches.
REQ-007 d_out  output  WIDTH  Registered, synchronised, debounced levels.
REQ-008 rise  output  WIDTH  Registered one-cycle pulse when d_out[i] goes 0->1.
REQ-009 fall  output  WIDTH  Registered one-cycle pulse when d_out[i] goes 1->0.

Function
REQ-010 Each channel SHALL pass d_in[i] through a STAGES-deep flop chain; the last stage is sync[i].
REQ-011 Each channel SHALL hold a counter of width $clog2(FILTER_LEN+1), saturating-free, never exceeding FILTER_LEN-1.
REQ-012 When sync[i] equals d_out[i], the counter SHALL be cleared to 0 on the next edge.
REQ-013 When sync[i] differs from d_out[i] and counter < FILTER_LEN-1, the counter SHALL increment by 1.
REQ-014 When sync[i] differs from d_out[i] and counter == FILTER_LEN-1, the following SHALL occur on the same edge: d_out[i] <= sync[i], counter <= 0, and rise[i] or fall[i] <= 1 according to direction.
REQ-015 Any cycle in which sync[i] returns to d_out[i] before acceptance SHALL discard the partial count, so pulses shorter than FILTER_LEN synchronised cycles produce no output change.
REQ-016 With FILTER_LEN=1, d_out[i] SHALL follow sync[i] with one cycle of delay.
REQ-017 Latency from a clean d_in step sampled at edge k to the d_out change SHALL be exactly STAGES+FILTER_LEN-1 further edges, i.e. visible after edge k+STAGES+FILTER_LEN-1.
REQ-018 rise[i] and fall[i] SHALL be high for exactly one cycle per accepted transition, coincident with the d_out[i] change, and never high together.
REQ-019 In every other cycle, rise[i] and fall[i] SHALL be 0.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.

Reset
REQ-021 While reset=0, all synchroniser flops, counters, d_out, rise and fall SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-count SHALL discard all partial counts.
REQ-023 After reset deasserts, an input already high SHALL be accepted after STAGES+FILTER_LEN edges and SHALL produce a rise pulse.

Structure
REQ-024 Synchroniser flops SHALL carry ASYNC_REG="TRUE".
REQ-025 The existing synchroniser module (WIDTH, STAGES) SHALL be instantiated once as the only sub-module for the synchronisation stage.
REQ-026 No shared package SHALL be required; the counter width SHALL be a localparam.
REQ-027 The filter SHALL be a generate loop over WIDTH channels.

Verification (WIDTH=4, STAGES=2, FILTER_LEN=4)
REQ-028 Reset scenario: hold reset=0 with d_in=4'hF -> d_out=rise=fall=0 throughout; release -> d_out becomes 4'hF after edge 6, with rise=4'hF for that one cycle only.
REQ-029 Step scenario: d_in[0] 0->1 before edge k, held -> d_out[0]=1 after edge k+5, rise[0] high one cycle, fall=0.
REQ-030 Glitch scenario: d_in[1] high for 3 cycles, then low -> d_out[1] stays 0, no rise or fall pulses.
REQ-031 Bounce scenario: d_in[2] pattern 3 high, 1 low, 4 high -> single rise[2] pulse, 4 cycles after the final run is synchronised; no earlier pulse.
REQ-032 Parallel scenario: d_in 4'b0000->4'b1010 then ->4'b0000 after 10 cycles -> rise=4'b1010 for one cycle, then later fall=4'b1010 for one cycle.
REQ-033 Reset-mid-count scenario: reset pulsed low 2 cycles into a count on d_in[3] -> all state 0; d_out[3] rises only after 6 full edges post-release.
